// File: rtl/int_ctrl_vec.sv
// Vectored, prioritised, nestable interrupt controller clocked on the falling edge of t3.
// Define INTC_LEVEL_TRIG_EN for level-sensitive requests; edge-triggered otherwise.
module int_ctrl_vec #(
    parameter int               N_SRC      = 4,
    parameter int               VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 8'hE0,
    parameter int               VEC_STRIDE = 4,
    parameter int               NEST_DEPTH = 2
) (
    input  logic                              t3,
    input  logic                              clr,
    input  logic [N_SRC-1:0]                  irq,
    input  logic                              mask_wr,
    input  logic [N_SRC-1:0]                  mask_din,
    input  logic                              ei,
    input  logic                              di,
    input  logic                              take,
    input  logic                              iret,
    output logic                              int_req,
    output logic [VEC_W-1:0]                  int_vec,
    output logic [N_SRC-1:0]                  in_service,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level,
    output logic                              en_int,
    output logic                              err
);
    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int LVL_W = $clog2(NEST_DEPTH + 1);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(NEST_DEPTH);

    logic [N_SRC-1:0] r_sync1, r_sync2, r_mask, r_ins;
    logic [LVL_W-1:0] r_lvl;
    logic             r_en, r_err;
    logic [VEC_W-1:0] r_vec;
    logic [IDX_W-1:0] r_stack [NEST_DEPTH];

    logic [N_SRC-1:0] w_pend, w_elig, w_win_oh, w_pop_oh;
    logic [IDX_W-1:0] w_win, w_top;
    logic [VEC_W-1:0] w_vec;
    logic             w_req, w_do_take, w_do_iret;

`ifdef INTC_LEVEL_TRIG_EN
    assign w_pend = r_sync2;
`else
    logic [N_SRC-1:0] r_sync_d, r_pend;

    // a new edge wins over the take clear so a back-to-back request is not lost
    always_ff @(negedge t3 or negedge clr) begin
        if (!clr) begin
            r_sync_d <= '0;
            r_pend   <= '0;
        end else begin
            r_sync_d <= r_sync2;
            r_pend   <= (r_pend & ~(w_do_take ? w_win_oh : '0)) | (r_sync2 & ~r_sync_d);
        end
    end
    assign w_pend = r_pend;
`endif

    assign w_elig = w_pend & ~r_mask;

    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_elig[i]) w_win = IDX_W'(i);
        w_top = '0;
        for (int k = 0; k < NEST_DEPTH; k++)
            if (r_lvl == LVL_W'(k + 1)) w_top = r_stack[k];
    end

    assign w_req     = r_en && (|w_elig) && (r_lvl < DEPTH_L) &&
                       ((r_lvl == '0) || (w_win < w_top));
    assign w_do_iret = iret && (r_lvl != '0);
    assign w_do_take = take && w_req && !iret;
    assign w_win_oh  = N_SRC'(1) << w_win;
    assign w_pop_oh  = N_SRC'(1) << w_top;
    assign w_vec     = VEC_BASE + VEC_W'(VEC_STRIDE * int'(w_win));

    always_ff @(negedge t3 or negedge clr) begin
        if (!clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_mask  <= '0;
            r_ins   <= '0;
            r_lvl   <= '0;
            r_en    <= 1'b1;
            r_err   <= 1'b0;
            r_vec   <= VEC_BASE;
            for (int k = 0; k < NEST_DEPTH; k++) r_stack[k] <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
            if (mask_wr) r_mask <= mask_din;

            if (w_do_iret) begin
                r_lvl <= r_lvl - LVL_W'(1);
                r_ins <= r_ins & ~w_pop_oh;
            end else if (w_do_take) begin
                r_lvl <= r_lvl + LVL_W'(1);
                r_ins <= r_ins | w_win_oh;
                r_vec <= w_vec;
                for (int k = 0; k < NEST_DEPTH; k++)
                    if (r_lvl == LVL_W'(k)) r_stack[k] <= w_win;
            end

            // take/iret override ei/di; di beats ei
            if (w_do_take)      r_en <= 1'b0;
            else if (w_do_iret) r_en <= 1'b1;
            else if (di)        r_en <= 1'b0;
            else if (ei)        r_en <= 1'b1;

            if ((take && !w_req) || (iret && r_lvl == '0) || (take && iret))
                r_err <= 1'b1;
        end
    end

    assign int_req    = w_req;
    assign int_vec    = r_vec;
    assign in_service = r_ins;
    assign nest_level = r_lvl;
    assign en_int     = r_en;
    assign err        = r_err;
endmodule

// File: tb/tb_int_ctrl_vec.sv
// Directed scoreboard bench for int_ctrl_vec: expected state snapshots queued per beat,
// compared by a monitor on the rising edge of t3.
module tb_int_ctrl_vec;
    logic       t3 = 1'b1;
    logic       clr;
    logic [3:0] irq, mask_din, in_service;
    logic       mask_wr, ei, di, take, iret;
    logic       int_req, en_int, err;
    logic [7:0] int_vec;
    logic [1:0] nest_level;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       req;
        logic [7:0] vec;
        logic [3:0] ins;
        logic [1:0] lvl;
        logic       en;
        logic       err;
    } snap_t;

    snap_t q[$];
    logic       e_req, e_en, e_err;
    logic [7:0] e_vec;
    logic [3:0] e_ins;
    logic [1:0] e_lvl;

    int_ctrl_vec dut (
        .t3(t3), .clr(clr), .irq(irq), .mask_wr(mask_wr), .mask_din(mask_din),
        .ei(ei), .di(di), .take(take), .iret(iret), .int_req(int_req),
        .int_vec(int_vec), .in_service(in_service), .nest_level(nest_level),
        .en_int(en_int), .err(err)
    );

    always #5 t3 = ~t3;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge t3) begin
        if (q.size() > 0) begin
            snap_t s;
            s = q.pop_front();
            chk("int_req",    int'(int_req),    int'(s.req));
            chk("int_vec",    int'(int_vec),    int'(s.vec));
            chk("in_service", int'(in_service), int'(s.ins));
            chk("nest_level", int'(nest_level), int'(s.lvl));
            chk("en_int",     int'(en_int),     int'(s.en));
            chk("err",        int'(err),        int'(s.err));
        end
    end

    task automatic push();
        snap_t s;
        s.req = e_req; s.vec = e_vec; s.ins = e_ins;
        s.lvl = e_lvl; s.en = e_en;   s.err = e_err;
        q.push_back(s);
    endtask

    task automatic set_reset_exp();
        e_req = 0; e_vec = 8'hE0; e_ins = 0; e_lvl = 0; e_en = 1; e_err = 0;
    endtask

    task automatic tick();
        @(negedge t3);
        push();
        @(posedge t3);
        #1;
        take = 0; iret = 0; ei = 0; di = 0; mask_wr = 0;
    endtask

    // edge-mode request pulse on channel ch; int_req becomes fin on the third edge
    task automatic pulse(input int ch, input logic fin);
        irq = 4'(1 << ch);
        tick();
        irq = 0;
        tick();
        e_req = fin;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 0; irq = 0; mask_wr = 0; mask_din = 0;
        ei = 0; di = 0; take = 0; iret = 0;
        set_reset_exp();
        #2 push();
        @(posedge t3);
        #1 clr = 1;

`ifdef INTC_LEVEL_TRIG_EN
        irq = 4'b0001;
        tick();
        e_req = 1; tick();
        take = 1; e_vec = 8'hE0; e_ins = 4'b0001; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; e_req = 1; tick();
        irq = 0;
        tick();
        e_req = 0; tick();
`else
        // single request on channel 2
        pulse(2, 1);
        take = 1; e_vec = 8'hE8; e_ins = 4'b0100; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; tick();

        // simultaneous channels 1 and 3
        irq = 4'b1010; tick();
        irq = 0; tick();
        e_req = 1; tick();
        take = 1; e_vec = 8'hE4; e_ins = 4'b0010; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; e_req = 1; tick();
        take = 1; e_vec = 8'hEC; e_ins = 4'b1000; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; tick();

        // nesting: channel 0 preempts channel 2, channel 1 blocked by full depth
        pulse(2, 1);
        take = 1; e_vec = 8'hE8; e_ins = 4'b0100; e_lvl = 1; e_en = 0; e_req = 0; tick();
        ei = 1; e_en = 1; tick();
        pulse(0, 1);
        take = 1; e_vec = 8'hE0; e_ins = 4'b0101; e_lvl = 2; e_en = 0; e_req = 0; tick();
        pulse(1, 0);
        ei = 1; e_en = 1; tick();
        iret = 1; e_ins = 4'b0100; e_lvl = 1; e_req = 1; tick();
        iret = 1; e_ins = 0; e_lvl = 0; tick();
        take = 1; e_vec = 8'hE4; e_ins = 4'b0010; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; tick();

        // masking and ei/di priority
        mask_wr = 1; mask_din = 4'b0001; tick();
        pulse(0, 0);
        mask_wr = 1; mask_din = 4'b0000; e_req = 1; tick();
        ei = 1; di = 1; e_en = 0; e_req = 0; tick();

        // protocol errors
        iret = 1; e_err = 1; tick();
        take = 1; tick();

        // new edge coinciding with take, mask write coinciding with take
        ei = 1; irq = 4'b0001; e_en = 1; e_req = 1; tick();
        irq = 0; tick();
        take = 1; mask_wr = 1; mask_din = 4'b0001;
        e_vec = 8'hE0; e_ins = 4'b0001; e_lvl = 1; e_en = 0; e_req = 0; tick();
        mask_wr = 1; mask_din = 4'b0000; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; e_req = 1; tick();
        take = 1; e_ins = 4'b0001; e_lvl = 1; e_en = 0; e_req = 0; tick();
        iret = 1; e_ins = 0; e_lvl = 0; e_en = 1; tick();

        // asynchronous reset inside a handler
        pulse(3, 1);
        take = 1; e_vec = 8'hEC; e_ins = 4'b1000; e_lvl = 1; e_en = 0; e_req = 0; tick();
        clr = 0;
        #2;
        set_reset_exp();
        push();
        @(posedge t3);
        #1 clr = 1;
        tick();
`endif

        repeat (2) @(posedge t3);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
